// File: rtl/fb_reader.sv
// Framebuffer reader: Wishbone classic read master feeding a first-word-fall-through
// pixel FIFO that the display pipeline drains through a valid/ready stream.

module fb_reader_fifo #(
    parameter int DW    = 25,
    parameter int DEPTH = 256
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DW-1:0]            wdata,
    output logic [DW-1:0]            rdata,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE      = (AW+1)'(1);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          do_push, do_pop;

    assign valid   = (count != '0);
    assign do_push = push && (count != FULL_CNT);
    assign do_pop  = pop && valid;
    // Head is gated so the stream shows zeros whenever nothing is buffered.
    assign rdata   = valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + ONE;
                2'b01:   count <= count - ONE;
                default: count <= count;
            endcase
        end
    end
endmodule

module fb_reader #(
    parameter int          HDISP      = 800,
    parameter int          VDISP      = 480,
    parameter logic [31:0] BASE_ADR   = 32'h0,
    parameter int          FIFO_DEPTH = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        wshb_cyc,
    output logic        wshb_stb,
    output logic        wshb_we,
    output logic [3:0]  wshb_sel,
    output logic [2:0]  wshb_cti,
    output logic [1:0]  wshb_bte,
    output logic [31:0] wshb_adr,
    input  logic [31:0] wshb_dat_sm,
    input  logic        wshb_ack,
    input  logic        resync,
    output logic [23:0] pix_data,
    output logic        pix_sof,
    output logic        pix_valid,
    input  logic        pix_ready
);
    localparam int XW = (HDISP > 1) ? $clog2(HDISP) : 1;
    localparam int YW = (VDISP > 1) ? $clog2(VDISP) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [XW-1:0] X_LAST   = XW'(HDISP - 1);
    localparam logic [YW-1:0] Y_LAST   = YW'(VDISP - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] ALMOST   = CW'(FIFO_DEPTH - 1);
    localparam logic [31:0]   LAST_ADR = BASE_ADR + 32'(4 * (HDISP * VDISP - 1));

    typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

    typedef struct packed {
        logic        sof;
        logic [23:0] rgb;
    } pix_t;

    state_t          state, state_nxt;
    logic            armed;
    logic [XW-1:0]   x;
    logic [YW-1:0]   y;
    logic [CW-1:0]   fill;
    logic            push, pop, fills_up;
    pix_t            wr_pix, rd_pix;
    logic            unused_dat;

    assign unused_dat = ^wshb_dat_sm[31:24];

    assign wshb_we  = 1'b0;
    assign wshb_sel = 4'b0111;
    assign wshb_cti = 3'b000;
    assign wshb_bte = 2'b00;

    // An ack coinciding with resync belongs to the aborted frame and is dropped.
    assign push     = (state == REQ) && wshb_ack && !resync;
    assign pop      = pix_valid && pix_ready;
    assign fills_up = (fill == ALMOST) && !pop;

    assign wr_pix.sof = (x == '0) && (y == '0);
    assign wr_pix.rgb = wshb_dat_sm[23:0];

    fb_reader_fifo #(
        .DW    ($bits(pix_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (resync),
        .push  (push),
        .pop   (pop),
        .wdata (wr_pix),
        .rdata (rd_pix),
        .valid (pix_valid),
        .count (fill)
    );

    assign pix_data = rd_pix.rgb;
    assign pix_sof  = rd_pix.sof;

    // IDLE lasts one full cycle after reset release before the first request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            armed <= 1'b0;
        end else begin
            armed <= 1'b1;
            state <= resync ? IDLE : state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (armed) state_nxt = REQ;
            REQ:  if (wshb_ack && fills_up) state_nxt = HOLD;
            HOLD: if (fill != FULL_CNT) state_nxt = REQ;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        wshb_cyc = (state == REQ);
        wshb_stb = (state == REQ);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x        <= '0;
            y        <= '0;
            wshb_adr <= BASE_ADR;
        end else if (resync) begin
            x        <= '0;
            y        <= '0;
            wshb_adr <= BASE_ADR;
        end else if (push) begin
            if (x == X_LAST) begin
                x <= '0;
                y <= (y == Y_LAST) ? '0 : y + YW'(1);
            end else begin
                x <= x + XW'(1);
            end
            wshb_adr <= (wshb_adr == LAST_ADR) ? BASE_ADR : wshb_adr + 32'd4;
        end
    end
endmodule

// File: tb/tb_fb_reader.sv
// Directed bench for fb_reader on a small 8x4 frame with a 4-entry FIFO.

module tb_fb_reader;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wshb_cyc, wshb_stb, wshb_we, wshb_ack;
    logic [3:0]  wshb_sel;
    logic [2:0]  wshb_cti;
    logic [1:0]  wshb_bte;
    logic [31:0] wshb_adr, wshb_dat_sm;
    logic        resync = 1'b0;
    logic [23:0] pix_data;
    logic        pix_sof, pix_valid;
    logic        pix_ready = 1'b0;

    logic        rnd_ack = 1'b0;
    logic        slave_en = 1'b0;
    logic        wait_mode = 1'b0;
    int          wcnt = 0;
    int          n_chk = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    assign wshb_ack    = rnd_ack | (wshb_stb & (wait_mode ? (wcnt == 3) : slave_en));
    assign wshb_dat_sm = {8'hEE, wshb_adr[23:0]};

    always @(posedge clk)
        wcnt <= (wshb_stb && !wshb_ack) ? wcnt + 1 : 0;

    fb_reader #(
        .HDISP      (8),
        .VDISP      (4),
        .BASE_ADR   (32'h0),
        .FIFO_DEPTH (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wshb_cyc    (wshb_cyc),
        .wshb_stb    (wshb_stb),
        .wshb_we     (wshb_we),
        .wshb_sel    (wshb_sel),
        .wshb_cti    (wshb_cti),
        .wshb_bte    (wshb_bte),
        .wshb_adr    (wshb_adr),
        .wshb_dat_sm (wshb_dat_sm),
        .wshb_ack    (wshb_ack),
        .resync      (resync),
        .pix_data    (pix_data),
        .pix_sof     (pix_sof),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_resync();
        resync = 1'b1;
        step();
        resync = 1'b0;
    endtask

    initial begin
        int na, np, c;
        logic prev_pend;
        logic [31:0] prev_adr;

        // reset with random acks on the bus
        repeat (5) begin
            rnd_ack = 1'($urandom);
            step();
        end
        chk("rst_cyc", wshb_cyc, 0);
        chk("rst_stb", wshb_stb, 0);
        chk("rst_adr", wshb_adr, 0);
        chk("rst_valid", pix_valid, 0);
        chk("rst_data", pix_data, 0);
        chk("rst_sof", pix_sof, 0);
        chk("const_bus", {wshb_we, wshb_sel, wshb_cti, wshb_bte}, {1'b0, 4'b0111, 3'b0, 2'b0});
        rnd_ack = 1'b0;
        slave_en = 1'b1;
        pix_ready = 1'b1;
        rst_n = 1'b1;
        step();
        chk("rel_edge1_stb", wshb_stb, 0);
        step();
        chk("rel_edge2_stb", wshb_stb, 1);

        // full frame plus the wrap back to pixel 0
        na = 0;
        np = 0;
        for (c = 0; c < 300 && (na < 33 || np < 33); c++) begin
            if (wshb_stb && wshb_ack && na < 33) begin
                chk("frame_adr", wshb_adr, (na * 4) % 128);
                na++;
            end
            if (pix_valid && pix_ready && np < 33) begin
                chk("frame_data", pix_data, (np * 4) % 128);
                chk("frame_sof", pix_sof, (np % 32) == 0);
                np++;
            end
            step();
        end
        chk("frame_acks", na, 33);
        chk("frame_pops", np, 33);

        // backpressure: exactly FIFO_DEPTH acks then the bus goes quiet
        pix_ready = 1'b0;
        do_resync();
        chk("bp_flush", pix_valid, 0);
        na = 0;
        repeat (20) begin
            if (wshb_stb && wshb_ack) na++;
            step();
        end
        chk("bp_acks", na, 4);
        chk("bp_stb_low", wshb_stb, 0);
        chk("bp_cyc_low", wshb_cyc, 0);
        chk("bp_head", pix_data, 0);
        chk("bp_head_sof", pix_sof, 1);
        pix_ready = 1'b1;
        step();
        pix_ready = 1'b0;
        chk("bp_pop_stb", wshb_stb, 0);
        chk("bp_pop_head", pix_data, 4);
        step();
        chk("bp_restart_stb", wshb_stb, 1);
        chk("bp_restart_adr", wshb_adr, 16);

        // push and pop together at DEPTH-1
        do_resync();
        repeat (4) step();
        chk("pp_pre_head", pix_data, 0);
        chk("pp_pre_stb", wshb_stb, 1);
        chk("pp_pre_adr", wshb_adr, 12);
        pix_ready = 1'b1;
        step();
        pix_ready = 1'b0;
        chk("pp_stay_req", wshb_stb, 1);
        chk("pp_head", pix_data, 4);
        chk("pp_adr", wshb_adr, 16);
        step();
        chk("pp_now_full", wshb_stb, 0);
        pix_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("pp_order", pix_data, 4 + 4 * k);
            step();
        end

        // wait-state slave: request held stable until ack
        wait_mode = 1'b1;
        do_resync();
        np = 0;
        prev_pend = 1'b0;
        prev_adr = '0;
        for (c = 0; c < 200 && np < 6; c++) begin
            if (prev_pend) begin
                chk("ws_stb_hold", wshb_stb, 1);
                chk("ws_adr_hold", wshb_adr, prev_adr);
            end
            if (pix_valid && pix_ready) begin
                chk("ws_data", pix_data, np * 4);
                np++;
            end
            prev_pend = wshb_stb && !wshb_ack;
            prev_adr = wshb_adr;
            step();
        end
        chk("ws_pops", np, 6);

        // resync colliding with an ack at adr 40
        wait_mode = 1'b0;
        do_resync();
        for (c = 0; c < 100 && !(wshb_stb && wshb_adr == 32'd40); c++) step();
        chk("rs_found_adr", wshb_adr, 40);
        chk("rs_ack_same_cycle", wshb_ack, 1);
        resync = 1'b1;
        step();
        resync = 1'b0;
        chk("rs_flushed", pix_valid, 0);
        chk("rs_cyc_low", wshb_cyc, 0);
        pix_ready = 1'b0;
        step();
        chk("rs_cyc_back", wshb_cyc, 1);
        chk("rs_adr_base", wshb_adr, 0);
        step();
        chk("rs_valid", pix_valid, 1);
        chk("rs_data", pix_data, 0);
        chk("rs_sof", pix_sof, 1);

        // asynchronous reset in the middle of a cycle
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_cyc", wshb_cyc, 0);
        chk("arst_stb", wshb_stb, 0);
        chk("arst_adr", wshb_adr, 0);
        chk("arst_valid", pix_valid, 0);
        chk("arst_data", pix_data, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/fb_reader.md
# fb_reader

Wishbone master that reads the framebuffer frame by frame and converts it into a pixel stream for the display pipeline. It issues classic single read cycles to consecutive 32-bit words from `BASE_ADR`, and buffers the returned RGB pixels in an internal first-word-fall-through FIFO. The display side drains the FIFO through a valid/ready stream. It is the consumer counterpart of the test-pattern writer that fills the same framebuffer.

## Interface
- `HDISP`, 800, displayed pixels per line
- `VDISP`, 480, displayed lines per frame
- `BASE_ADR`, 32'h0, byte address of pixel (0,0)
- `FIFO_DEPTH`, 256, FIFO entries, power of two ≥ 4

Clock is `clk`; reset is `rst_n`, asynchronous, active-low.

- `clk`  in  1  system clock, all logic on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `wshb_cyc`  out  1  bus cycle in progress
- `wshb_stb`  out  1  transfer request
- `wshb_we`  out  1  constant 0 (reads only)
- `wshb_sel`  out  4  constant 4'b0111 (RGB bytes)
- `wshb_cti`  out  3  constant 0 (classic cycle)
- `wshb_bte`  out  2  constant 0
- `wshb_adr`  out  32  byte address of current word
- `wshb_dat_sm`  in  32  read data, bits 23:0 = RGB
- `wshb_ack`  in  1  transfer acknowledge
- `resync`  in  1  single-cycle pulse: abort, flush, restart at frame start
- `pix_data`  out  24  RGB at FIFO head
- `pix_sof`  out  1  head pixel is (0,0) of a frame
- `pix_valid`  out  1  FIFO not empty
- `pix_ready`  in  1  sink accepts head pixel this cycle

## Operation
- Reset values: `wshb_cyc`=`wshb_stb`=0, `wshb_adr`=`BASE_ADR`, x=y=0, FIFO empty, `pix_valid`=0, `pix_data`=0, `pix_sof`=0.
- FSM, registered:
  - IDLE: entered after reset. Goes to REQ on the next edge.
  - REQ: `cyc`=`stb`=1. The request is held until `wshb_ack`.
  - HOLD: `cyc`=`stb`=0. Entered when an ack brings the FIFO count to `FIFO_DEPTH`. Goes to REQ on the first cycle the count is below `FIFO_DEPTH`.
- On ack in REQ:
  - Push {sof=(x==0 && y==0), `wshb_dat_sm[23:0]`} into the FIFO.
  - Advance x, y and the address.
  - Stay in REQ unless the FIFO becomes full, then go to HOLD.
- Counters:
  - x wraps at `HDISP`-1 to 0 and increments y.
  - y wraps at `VDISP`-1 to 0.
  - `wshb_adr` adds 4 per ack. At `BASE_ADR`+4*(HDISP*VDISP-1) it wraps to `BASE_ADR`.
  - Widths are `$clog2` of the limits. Address arithmetic is 32-bit, and no wrap occurs outside the frame.
- Pop: `pix_valid && pix_ready` removes the head entry.
- A push and a pop in the same cycle leave the count unchanged. This is legal at full (no push occurs) and at empty (no pop occurs).
- `pix_data` and `pix_sof` are 0 whenever `pix_valid`=0.
- `resync` has priority over everything else:
  - Next edge: FIFO flushed, x=y=0, `wshb_adr`=`BASE_ADR`, state IDLE, `cyc`=`stb`=0.
  - Any `wshb_ack` in the same cycle as `resync` is discarded.
- Bus errors and retries are not supported. The `err` and `rty` signals are absent.

## Timing
- First request: `cyc`/`stb` rise on the 2nd rising edge after `rst_n` deasserts (one cycle in IDLE).
- Zero-wait slave (ack in the cycle `stb` is first seen high): one word per cycle, with `stb` continuously high while in REQ.
- Ack sampled at edge N: the pixel is visible on `pix_valid`/`pix_data` after edge N, and the address advances after edge N.
- Full: after the ack that fills the FIFO, `stb` is 0 from the next cycle. After the first pop, `stb` is high again one cycle later.
- `resync` asserted at edge N: `pix_valid`=0 and `cyc`=0 after edge N; `cyc`=1 again after edge N+1.
- Reset mid-cycle: all outputs return to their reset values immediately and asynchronously.

## Test plan
- Reset: hold `rst_n`=0 with random `ack` -> `cyc`=`stb`=0, `adr`=0, `pix_valid`=0. After release, `stb`=1 on the 2nd edge.
- Full frame: HDISP=8, VDISP=4, zero-wait slave returning data = address, `pix_ready`=1.
  - Addresses run 0,4,…,124, then 0.
  - `pix_sof`=1 only on pixels 0 and 32.
  - Data matches the address.
- Backpressure: `FIFO_DEPTH`=4, `pix_ready`=0 -> exactly 4 acks, then `stb`=0 stays low. A one-cycle `pix_ready` gives 1 pop and `stb`=1 one cycle later.
- Wait states: ack delayed by 3 cycles each -> `stb` and `adr` stay stable until ack, and no word is lost or duplicated.
- Resync during a pending request (adr=40) with simultaneous ack -> ack data is dropped, FIFO is empty, the next request has `adr`=0, and the next pixel has `pix_sof`=1.
- Push and pop together at count `FIFO_DEPTH`-1 -> count is unchanged, the state stays REQ, and the output order is preserved.
